// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: scheduler state encoding,
// byte/message geometry, the bit-period constant and a byte-lane helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } uart_sched_state_t;

  localparam int UART_BYTE_W    = 8;
  localparam int UART_MAX_BYTES = 4;
  localparam int UART_BIT_CNT   = 5208;

  // Pick byte lane idx out of a message word; lane 0 is the first byte sent.
  function automatic logic [UART_BYTE_W-1:0] word_byte(input logic [31:0] word,
                                                       input logic [1:0]  idx);
    logic [UART_BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps
// modulo NREQ; the first asserted request wins.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      grant_idx,
  output logic            grant_any
);

  logic [3:0] req4;
  logic [2:0] sum;
  logic [1:0] cand;
  logic       found;
  logic [1:0] sel;

  assign req4 = 4'(req);

  // Walk the requesters in priority order starting at ptr, then decode one-hot.
  always_comb begin
    found = 1'b0;
    sel   = 2'd0;
    sum   = 3'd0;
    cand  = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + 3'(k);
      if (sum >= 3'(NREQ)) begin
        sum = sum - 3'(NREQ);
      end else begin
        sum = sum;
      end
      cand = sum[1:0];
      if (!found && req4[cand]) begin
        found = 1'b1;
        sel   = cand;
      end else begin
        found = found;
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      grant[j] = found && (sel == 2'(j));
    end
    grant_idx = sel;
    grant_any = found;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding 1-4 byte messages from NREQ requesters into
// the single UART byte transmitter through its TX_DATA/TX_EN handshake.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [32*NREQ-1:0] req_data,
  input  logic [2*NREQ-1:0] req_len,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   req_done,
  output logic [7:0]        tx_data,
  output logic              tx_en,
  input  logic              tx_busy,
  output logic              sched_busy,
  output logic [1:0]        grant_id
);

  uart_sched_state_t state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [31:0]     word_q, word_d;
  logic [1:0]      len_q, len_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [1:0]      grant_id_q, grant_id_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [NREQ-1:0] req_done_q, req_done_d;
  logic            sched_busy_q, sched_busy_d;

  logic [NREQ-1:0] arb_grant;
  logic [1:0]      arb_idx;
  logic            arb_any;
  logic [31:0]     sel_word;
  logic [1:0]      sel_len;
  logic [NREQ-1:0] done_onehot;
  logic [1:0]      ptr_next;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  // Mux the granted requester's word/len and decode the completion vector.
  always_comb begin
    sel_word = 32'h0000_0000;
    sel_len  = 2'd0;
    for (int j = 0; j < NREQ; j++) begin
      if (arb_grant[j]) begin
        sel_word = req_data[32*j +: 32];
        sel_len  = req_len[2*j +: 2];
      end else begin
        sel_word = sel_word;
      end
      done_onehot[j] = (grant_id_q == 2'(j));
    end
    // The pointer wraps at NREQ, not at the 2-bit limit.
    if (grant_id_q == 2'(NREQ - 1)) begin
      ptr_next = 2'd0;
    end else begin
      ptr_next = grant_id_q + 2'd1;
    end
  end

  // Next-state and output logic of the scheduler FSM.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    word_d     = word_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    grant_id_d = grant_id_q;
    tx_data_d  = tx_data_q;
    req_done_d = '0;
    req_ready  = '0;
    tx_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = arb_grant;
        if (arb_any) begin
          word_d     = sel_word;
          len_d      = sel_len;
          byte_idx_d = 2'd0;
          grant_id_d = arb_idx;
          tx_data_d  = word_byte(sel_word, 2'd0);
          state_d    = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // A frame already on the wire blocks the strobe until it finishes.
        if (!tx_busy) begin
          tx_en   = 1'b1;
          state_d = ST_WAIT_BUSY;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else begin
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (byte_idx_q == len_q) begin
            req_done_d = done_onehot;
            ptr_d      = ptr_next;
            state_d    = ST_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            tx_data_d  = word_byte(word_q, byte_idx_q + 2'd1);
            state_d    = ST_ISSUE;
          end
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    sched_busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers; reset drops any message in flight.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 2'd0;
      word_q       <= 32'h0000_0000;
      len_q        <= 2'd0;
      byte_idx_q   <= 2'd0;
      grant_id_q   <= 2'd0;
      tx_data_q    <= 8'h00;
      req_done_q   <= '0;
      sched_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      word_q       <= word_d;
      len_q        <= len_d;
      byte_idx_q   <= byte_idx_d;
      grant_id_q   <= grant_id_d;
      tx_data_q    <= tx_data_d;
      req_done_q   <= req_done_d;
      sched_busy_q <= sched_busy_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign req_done   = req_done_q;
  assign sched_busy = sched_busy_q;
  assign grant_id   = grant_id_q;

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Multi-requester scheduler in front of the single UART byte transmitter (`sender`). Accepts 1–4-byte messages from NREQ independent requesters, arbitrates round-robin, and feeds the transmitter one byte at a time through its TX_DATA/TX_EN handshake. Bytes go out LSB first. The scheduler sits between the CPU/peripheral side (MMIO print port, debug dump port, …) and `sender`, and is the only block that drives the transmitter.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..4)

Ports:
- sysclk  in  1  system clock
- reset  in  1  asynchronous, active-low
- req_valid  in  NREQ  per-requester message pending; held until accepted
- req_data  in  32*NREQ  message word for requester i at [32i+31:32i]; byte 0 = [7:0]
- req_len  in  2*NREQ  byte count minus one for requester i at [2i+1:2i]
- req_ready  out  NREQ  one-hot; the handshake completes on the edge where req_valid[i] & req_ready[i]
- req_done  out  NREQ  one-cycle pulse when the last byte of requester i's message has left the transmitter
- tx_data  out  8  to sender TX_DATA
- tx_en  out  1  to sender TX_EN
- tx_busy  in  1  from sender sendstatus; high while a frame is in progress
- sched_busy  out  1  high whenever state ≠ IDLE
- grant_id  out  2  index of the requester currently being served; holds its last value in IDLE

## Operation
- Transmitter contract:
  - tx_en is sampled only while tx_busy = 0.
  - tx_busy rises on the edge after tx_en.
  - tx_busy falls once the stop bit and the trailing bit period complete.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req_valid is set, the round-robin search starts at pointer ptr and wraps modulo NREQ.
  - The first valid requester i gets req_ready[i] = 1 (combinational, IDLE only).
  - On that edge: latch word, latch len, byte_idx ← 0, grant_id ← i, go to ISSUE.
- ISSUE:
  - tx_data ← word byte[byte_idx]; tx_en = 1 for exactly this one cycle.
  - Go to WAIT_BUSY.
- WAIT_BUSY: wait for tx_busy = 1, then go to WAIT_DONE.
- WAIT_DONE: wait for tx_busy = 0, then:
  - If byte_idx == len: pulse req_done[grant_id], set ptr ← (grant_id + 1) mod NREQ, go to IDLE.
  - Otherwise: byte_idx ← byte_idx + 1, go to ISSUE.
- Arithmetic: byte_idx is 2 bits, with len ≤ 3, so it never wraps. ptr is 2 bits and wraps at NREQ, not at 4.
- tx_en is never asserted while tx_busy = 1. If tx_busy is already high on entry to ISSUE (foreign/stale frame), hold in ISSUE with tx_en = 0 until tx_busy = 0.
- req_valid or req_data changes after acceptance have no effect on the message in flight.
- A requester deasserting req_valid before it is accepted is simply skipped.

## Timing
- Reset values:
  - Outputs: tx_en 0, tx_data 0x00, req_ready 0, req_done 0, sched_busy 0, grant_id 0.
  - Internal: ptr 0, state IDLE.
- Reset mid-message: immediate return to IDLE. The in-flight message is dropped and no req_done pulse is issued. `sender` shares the same reset.
- Acceptance edge T → tx_en high during cycle T+1.
- Inter-byte gap: tx_busy falls at edge E → tx_en high in cycle E+1, then busy again at E+2.
- req_done pulses during the cycle after tx_busy falls. A new acceptance is possible in that same cycle's IDLE (next cycle).
- Simultaneous requests: at most one grant per IDLE cycle. After serving i, requester i has the lowest priority.
- A request arriving while another is in flight waits. Worst-case wait is (NREQ−1) × 4 frames.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_sched_state_t`
  - byte width constant `UART_BYTE_W = 8`
  - `UART_MAX_BYTES = 4`
  - bit-period constant `UART_BIT_CNT = 5208` (shared with `sender` and the testbench)
- Sub-module `rr_arbiter`:
  - inputs: request vector, ptr
  - outputs: one-hot grant and index
  - purely combinational
- The top holds the FSM, the latched word/len/byte_idx, and ptr.

## Test plan
- Single request: req 0, data 0x44332211, len 3 → tx_en pulses with tx_data 0x11, 0x22, 0x33, 0x44 in order; one req_done[0] after the 4th tx_busy fall; UART_TX frames match.
- Contention: req 0 and req 1 valid together with ptr = 0, len 0, data 0xA5 / 0x5A → 0xA5 sent first, then 0x5A; ptr ends at 0; each req_done pulses once.
- Fairness: req 0 re-asserts immediately after done while req 1 waits → req 1 served next; grants strictly alternate over 6 messages.
- Handshake safety: tx_busy forced high when entering ISSUE → tx_en stays 0 until tx_busy drops, then exactly one tx_en pulse.
- Reset mid-message: assert reset during byte 2 of a 4-byte message → all outputs at reset values, no req_done; a fresh 1-byte request then completes normally.
- Latency check: acceptance edge → tx_en in the next cycle; tx_busy fall → next tx_en after exactly 1 cycle.
